// File: rtl/bp_be_dual_mem_arbiter.sv
// Dual-issue memory arbiter: merges two pipe request streams onto one D$
// request port, keeps a credit count of in-flight requests and routes
// in-order responses back to the pipe that issued them.
module bp_be_dual_mem_arbiter #(
   parameter int unsigned data_width_p      = 64,
   parameter int unsigned max_outstanding_p = 4
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,

   input  logic                                   req1_v_i,
   input  logic [data_width_p-1:0]                req1_data_i,
   output logic                                   req1_ready_o,

   input  logic                                   req2_v_i,
   input  logic [data_width_p-1:0]                req2_data_i,
   output logic                                   req2_ready_o,

   input  logic                                   flush_i,

   output logic                                   mem_v_o,
   output logic [data_width_p-1:0]                mem_data_o,
   input  logic                                   mem_ready_i,

   input  logic                                   resp_v_i,
   input  logic [data_width_p-1:0]                resp_data_i,

   output logic                                   resp1_v_o,
   output logic                                   resp2_v_o,
   output logic [data_width_p-1:0]                resp_data_o,

   output logic [$clog2(max_outstanding_p):0]     outstanding_o,
   output logic                                   idle_o,
   output logic                                   spurious_resp_o
);

   localparam int unsigned ptr_w = $clog2(max_outstanding_p);
   localparam int unsigned cnt_w = ptr_w + 1;
   localparam int unsigned rsv_w = cnt_w + 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   state_e                          state_q, state_d;
   logic [data_width_p-1:0]         hold_q, hold_d;
   logic [cnt_w-1:0]                cnt_q, cnt_d;
   logic [ptr_w-1:0]                wptr_q, wptr_d;
   logic [ptr_w-1:0]                rptr_q, rptr_d;
   logic [max_outstanding_p-1:0]    src_q, src_d;

   logic [rsv_w-1:0]                reserved_c;
   logic                            room1_c, room2_c;
   logic                            issue_src_c;
   logic                            issue_c, pop_c;

   // Credits already committed: in flight plus a held pipe-2 request.
   always_comb begin
      reserved_c = rsv_w'(cnt_q) + rsv_w'(state_q == ST_HOLD);
      room1_c    = (reserved_c + rsv_w'(1)) <= rsv_w'(max_outstanding_p);
      room2_c    = (reserved_c + rsv_w'(2)) <= rsv_w'(max_outstanding_p);
   end

   // Next-state and request-side outputs; pipe 1 always goes out first.
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      req1_ready_o = 1'b0;
      req2_ready_o = 1'b0;
      mem_v_o      = 1'b0;
      mem_data_o   = hold_q;
      issue_src_c  = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            if (!flush_i) begin
               req1_ready_o = mem_ready_i & room1_c;
               req2_ready_o = mem_ready_i & (req1_v_i ? room2_c : room1_c);
               mem_v_o      = (req1_v_i | req2_v_i) & room1_c;
               mem_data_o   = req1_v_i ? req1_data_i : req2_data_i;
               issue_src_c  = ~req1_v_i;
               if (req1_v_i & req2_v_i & req1_ready_o & req2_ready_o) begin
                  hold_d  = req2_data_i;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            mem_v_o = ~flush_i;
            if (flush_i | mem_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (reset_i) begin
         req1_ready_o = 1'b0;
         req2_ready_o = 1'b0;
         mem_v_o      = 1'b0;
      end
   end

   // Source FIFO, credit counter and response routing.
   always_comb begin
      issue_c         = mem_v_o & mem_ready_i;
      pop_c           = resp_v_i & (cnt_q != '0) & ~reset_i;
      resp1_v_o       = pop_c & ~src_q[rptr_q];
      resp2_v_o       = pop_c &  src_q[rptr_q];
      spurious_resp_o = resp_v_i & (cnt_q == '0) & ~reset_i;
      resp_data_o     = resp_data_i;
      outstanding_o   = cnt_q;
      idle_o          = (state_q == ST_IDLE) & (cnt_q == '0);

      src_d  = src_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (issue_c) begin
         src_d[wptr_q] = issue_src_c;
         wptr_d        = wptr_q + ptr_w'(1);
      end
      if (pop_c) begin
         rptr_d = rptr_q + ptr_w'(1);
      end
      if (issue_c & ~pop_c) begin
         cnt_d = cnt_q + cnt_w'(1);
      end else if (~issue_c & pop_c) begin
         cnt_d = cnt_q - cnt_w'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         cnt_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         src_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         src_q   <= src_d;
      end
   end

endmodule
